hazard_stall_ctrl: RTL

Pipeline sequencing controller for the ARM 5-stage core. It drives the enable and flush of the PC register, the enable and flush of if_id_reg, and the stall/bubble controls of ID/EX and EX/MEM. It resolves load-use hazards, taken-branch squashes, instruction-memory waits and data-memory waits, with a fixed priority order. It also keeps a saturating stall counter and a data-memory timeout flag.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/hazard_stall_ctrl_if.sv | 40 ++++
 rtl/hazard_stall_ctrl_hazard_detect.sv | 23 ++
 rtl/hazard_stall_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing control: state encoding and
// architectural register constants.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StFlush    = 2'd1,
    StImemWait = 2'd2,
    StDmemWait = 2'd3
  } pipe_state_e;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side hazard inputs and stage-register controls of the sequencing controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic [3:0]       id_rn;
  logic [3:0]       id_rm;
  logic [3:0]       id_rd;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_use_rd;
  logic             ex_load;
  logic [3:0]       ex_rd;
  logic             branch_taken;
  logic             imem_ready;
  logic             mem_access;
  logic             dmem_ready;
  logic             pc_enable;
  logic             if_id_enable;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             back_stall;
  logic [CNT_W-1:0] stall_count;
  logic             mem_timeout;

  modport master (
    output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd, ex_load, ex_rd,
           branch_taken, imem_ready, mem_access, dmem_ready,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_bubble, back_stall, stall_count,
           mem_timeout
  );

  modport slave (
    input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd, ex_load, ex_rd,
           branch_taken, imem_ready, mem_access, dmem_ready,
    output pc_enable, if_id_enable, if_id_flush, id_ex_bubble, back_stall, stall_count,
           mem_timeout
  );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID (as Rn, Rm or store source Rd).
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] id_rn,
  input  logic [3:0] id_rm,
  input  logic [3:0] id_rd,
  input  logic       id_use_rn,
  input  logic       id_use_rm,
  input  logic       id_use_rd,
  input  logic       ex_load,
  input  logic [3:0] ex_rd,
  output logic       lu
);

  always_comb begin
    lu = ex_load & ((id_use_rn & (ex_rd == id_rn)) |
                    (id_use_rm & (ex_rd == id_rm)) |
                    (id_use_rd & (ex_rd == id_rd)));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: prioritised stall/flush decode for the PC,
// IF/ID, ID/EX and back-end registers, plus stall counter and DMEM timeout.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam int unsigned TmoW      = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [2:0]  FlushInit = 3'(FLUSH_CYCLES - 1);

  pipe_state_e      state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic lu, dmem_stall, flushing;
  logic pc_enable, if_id_enable, if_id_flush, id_ex_bubble, back_stall;

  hazard_detect u_hazard_detect (
    .id_rn     (bus.id_rn),
    .id_rm     (bus.id_rm),
    .id_rd     (bus.id_rd),
    .id_use_rn (bus.id_use_rn),
    .id_use_rm (bus.id_use_rm),
    .id_use_rd (bus.id_use_rd),
    .ex_load   (bus.ex_load),
    .ex_rd     (bus.ex_rd),
    .lu        (lu)
  );

  assign dmem_stall = bus.mem_access & ~bus.dmem_ready;
  // A flush interrupted by a DMEM wait resumes once the wait ends.
  assign flushing   = (state_q == StFlush) | ((state_q == StDmemWait) & (flush_cnt_q != 3'd0));

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    tmo_cnt_d     = '0;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;
    pc_enable     = 1'b0;
    if_id_enable  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    back_stall    = 1'b0;

    if (!reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = StRun;
    end else if (dmem_stall) begin
      back_stall = 1'b1;
      state_d    = StDmemWait;
      if (tmo_cnt_q >= TmoW'(DMEM_TIMEOUT - 1)) begin
        tmo_cnt_d     = TmoW'(DMEM_TIMEOUT);
        mem_timeout_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      end
    end else if (flushing) begin
      if_id_flush = 1'b1;
      pc_enable   = bus.imem_ready;
      flush_cnt_d = flush_cnt_q - 3'd1;
      state_d     = (flush_cnt_q == 3'd1) ? StRun : StFlush;
    end else if (lu) begin
      id_ex_bubble = 1'b1;
      state_d      = StRun;
    end else if (bus.branch_taken) begin
      pc_enable   = 1'b1;
      if_id_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d     = StFlush;
        flush_cnt_d = FlushInit;
      end else begin
        state_d = StRun;
      end
    end else if (!bus.imem_ready) begin
      if_id_flush = 1'b1;
      state_d     = StImemWait;
    end else begin
      pc_enable    = 1'b1;
      if_id_enable = 1'b1;
      state_d      = StRun;
    end

    if (reset && !pc_enable && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StRun;
      flush_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc_enable    = pc_enable;
  assign bus.if_id_enable = if_id_enable;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.back_stall   = back_stall;
  assign bus.stall_count  = stall_count_q;
  assign bus.mem_timeout  = mem_timeout_q;

endmodule
